// File: rtl/ser_pkg.sv
// Shared definitions for the channel serializer: state encoding, default widths
// and the frame length helper.
package ser_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int FRAME_BITS = 2 + ADDR_W_DEF + DATA_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } ser_state_e;

    // Bits on the line per word: start + address + data + stop.
    function automatic int frame_bits(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/ser_bitcnt.sv
// Loadable bit-period down-counter; steps on bit_tick and parks at zero,
// where the terminal-count flag is raised.
module ser_bitcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/channel_serializer.sv
// Serializes {addr,data} words as start bit, address, data (MSB first) and stop
// bit, paced by bit_tick, with frame-end tracking and a sticky overrun flag.
module channel_serializer #(
    parameter int DATA_W = ser_pkg::DATA_W_DEF,
    parameter int ADDR_W = ser_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_tick,
    input  logic              sl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              frame_end,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              frame_sync,
    output logic              overrun
);

    import ser_pkg::*;

    localparam int FB    = frame_bits(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(FB);
    localparam int SR_W  = ADDR_W + DATA_W;

    // Counter holds "ticks remaining minus one"; zero means the stop bit is on the line.
    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(FB - 1);
    localparam logic [CNT_W-1:0] CNT_HDR_END  = CNT_W'(FB - 1 - ADDR_W);
    localparam logic [CNT_W-1:0] CNT_DATA_END = CNT_W'(1);

    ser_state_e       state_q;
    logic [SR_W-1:0]  sr_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             busy_q;
    logic             fe_q;
    logic             fs_q;
    logic             ovr_q;

    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             load_ok;
    logic             word_done;
    logic             fs_d;

    assign load_ok   = (state_q == ST_IDLE) && sl;
    assign word_done = (state_q == ST_STOP) && bit_tick && cnt_tc;
    assign fs_d      = word_done && (fe_q || frame_end);

    ser_bitcnt #(.W(CNT_W)) u_bitcnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_ok),
        .load_val_i (CNT_LOAD),
        .tick_i     (bit_tick && (state_q != ST_IDLE)),
        .count_o    (cnt),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            ser_out_q   <= 1'b1;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fe_q        <= 1'b0;
            fs_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            fs_q <= fs_d;

            if (sl && (state_q != ST_IDLE)) begin
                ovr_q <= 1'b1;
            end else if (fs_d) begin
                ovr_q <= 1'b0;
            end

            if (state_q != ST_IDLE) begin
                if (word_done) begin
                    fe_q <= 1'b0;
                end else if (frame_end) begin
                    fe_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    // A coincident bit_tick is dropped so the start bit gets a full period.
                    if (sl) begin
                        state_q     <= ST_HDR;
                        sr_q        <= {addr, data};
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        fe_q        <= frame_end;
                    end
                end
                ST_HDR: begin
                    if (bit_tick) begin
                        ser_out_q <= sr_q[SR_W-1];
                        sr_q      <= {sr_q[SR_W-2:0], 1'b0};
                        if (cnt == CNT_HDR_END) begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (cnt == CNT_DATA_END) begin
                            state_q     <= ST_STOP;
                            ser_out_q   <= 1'b1;
                            ser_valid_q <= 1'b0;
                        end else begin
                            ser_out_q <= sr_q[SR_W-1];
                            sr_q      <= {sr_q[SR_W-2:0], 1'b0};
                        end
                    end
                end
                ST_STOP: begin
                    if (word_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        sr_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign busy       = busy_q;
    assign frame_sync = fs_q;
    assign overrun    = ovr_q;

endmodule
